pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the word address of the first fetch after reset.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the PC, immediate and memory address width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port halt, input, 1 bit: stop sequencing at the next instruction boundary.
REQ-006 SHALL have port imem_req, output, 1 bit: fetch request.
REQ-007 SHALL have port imem_addr, output, ADDR_W bits: fetch word address, equal to pc.
REQ-008 SHALL have port imem_ack, input, 1 bit: imem_rdata valid this cycle.
REQ-009 SHALL have port imem_rdata, input, 32 bits: fetched instruction.
REQ-010 SHALL have port instr, output, 32 bits: latched instruction to decode.
REQ-011 SHALL have port instr_valid, output, 1 bit: instr offered to decode.
REQ-012 SHALL have port instr_ready, input, 1 bit: decode accepts instr.
REQ-013 SHALL have port ex_done, input, 1 bit: execute resolved; zero/branch/jump/imm valid.
REQ-014 SHALL have ports zero, branch and jump, each input, 1 bit: ALU zero flag, branch instruction, jump instruction.
REQ-015 SHALL have port imm, input, ADDR_W bits: two's-complement word offset.
REQ-016 SHALL have port pc, output, ADDR_W bits: address of the current instruction.
REQ-017 SHALL have port busy, output, 1 bit: high in any state except IDLE.

Function
REQ-018 SHALL implement the Moore FSM states IDLE, FETCH, ISSUE and EXEC.
REQ-019 SHALL transition IDLE->FETCH when halt=0, and otherwise stay in IDLE.
REQ-020 SHALL assert imem_req only in FETCH, and transition FETCH->ISSUE on imem_ack, capturing imem_rdata into instr on that edge.
REQ-021 SHALL hold imem_req high and imem_addr stable in FETCH until imem_ack, with no timeout.
REQ-022 SHALL assert instr_valid only in ISSUE, holding instr stable, and transition ISSUE->EXEC on instr_ready.
REQ-023 SHALL wait in EXEC for ex_done.
REQ-024 SHALL, on ex_done, compute pc <= pc + imm when (zero&branch)|jump, and pc <= pc + 1 otherwise.
REQ-025 SHALL, on ex_done, transition to IDLE when halt=1, and to FETCH otherwise.
REQ-026 SHALL compute addition modulo 2^ADDR_W, so that wrap-around is silent and a negative imm moves backward.
REQ-027 SHALL ignore imem_ack outside FETCH.
REQ-028 SHALL ignore instr_ready outside ISSUE.
REQ-029 SHALL ignore ex_done and the zero, branch, jump and imm inputs outside EXEC.
REQ-030 SHALL ignore halt in FETCH and ISSUE; halt SHALL take effect only in IDLE or when ex_done occurs.
REQ-031 SHALL make imem_ack and instr_ready arriving in the same cycle as entry into their state effective on the following edge, giving a minimum of 1 cycle per state.
REQ-032 SHALL give a minimum instruction period of 3 cycles (FETCH, ISSUE, EXEC), each with a single-cycle handshake.

Reset
REQ-033 SHALL, when rst_n=0 at an edge, set state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), and imem_req=instr_valid=busy=0.
REQ-034 SHALL allow reset mid-FETCH, ISSUE or EXEC to abandon the operation, with outputs returning to reset values the cycle after the reset edge and any late imem_ack ignored.
REQ-035 SHALL, after release with halt=0, assert imem_req with imem_addr=RESET_PC in the second cycle.

Structure
REQ-036 SHALL place the state enum, the NOP constant and the PC increment constant (1) in a shared package, pc_ctrl_pkg.
REQ-037 SHALL place the next-PC selection and adder in the combinational sub-module pc_next_calc (inputs pc, imm, zero, branch, jump; output pc_next).
REQ-038 SHALL keep all registers in pc_ctrl.

Verification
REQ-039 SHALL cover sequential flow: RESET_PC=0, ack and ready immediate, ex_done with branch=jump=0 -> imem_addr sequence 0,1,2, one fetch every 3 cycles.
REQ-040 SHALL cover a taken branch: pc=8, branch=1, zero=1, imm=32'hFFFF_FFFC -> next imem_addr=4; the same case with zero=0 -> 9.
REQ-041 SHALL cover jump with wrap: pc=32'hFFFF_FFFE, jump=1, imm=3 -> next imem_addr=1.
REQ-042 SHALL cover a memory stall: imem_ack delayed 5 cycles -> imem_req and imem_addr stable for 6 cycles, and instr equals the rdata sampled at ack.
REQ-043 SHALL cover halt with simultaneous ex_done at pc=4 (not taken) -> pc=5, state IDLE, busy=0; halt dropped -> fetch at 5.
REQ-044 SHALL cover reset mid-ISSUE: rst_n=0 for 1 cycle -> instr_valid=0 and pc=RESET_PC the next cycle, and a stray imem_ack is ignored.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the PC controller.
//   state_t : sequencer states IDLE, FETCH, ISSUE, EXEC
//   NOP     : instruction value held in instr after reset (addi x0,x0,0)
//   PC_INC  : word increment applied to pc for sequential flow
package pc_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, EXEC} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PC_INC = 1;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection and adder.
//   pc      in  : address of the current instruction
//   imm     in  : two's-complement word offset
//   zero    in  : ALU zero flag
//   branch  in  : current instruction is a conditional branch
//   jump    in  : current instruction is an unconditional jump
//   pc_next out : pc + imm when the branch is taken or on a jump, pc + 1 otherwise
module pc_next_calc
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic              zero,
  input  logic              branch,
  input  logic              jump,
  output logic [ADDR_W-1:0] pc_next
);
  // Sums are truncated to ADDR_W bits, so wrap-around is silent and a
  // negative imm steps backward.
  assign pc_next = ((zero & branch) | jump) ? pc + imm : pc + ADDR_W'(PC_INC);
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: instruction sequencer running FETCH -> ISSUE -> EXEC per instruction.
//   clk         in  : rising-edge clock
//   rst_n       in  : synchronous active-low reset
//   halt        in  : stop at the next instruction boundary (sampled in IDLE or on ex_done)
//   imem_req    out : fetch request, high only in FETCH
//   imem_addr   out : fetch word address, always equal to pc
//   imem_ack    in  : imem_rdata valid, honoured only in FETCH
//   imem_rdata  in  : fetched instruction
//   instr       out : latched instruction for decode
//   instr_valid out : instr offered to decode, high only in ISSUE
//   instr_ready in  : decode accepts instr, honoured only in ISSUE
//   ex_done     in  : execute resolved, honoured only in EXEC
//   zero/branch/jump/imm in : branch resolution inputs, used only with ex_done
//   pc          out : address of the current instruction
//   busy        out : high in every state except IDLE
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              ex_done,
  input  logic              zero,
  input  logic              branch,
  input  logic              jump,
  input  logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);
  state_t            state;
  logic [ADDR_W-1:0] pc_next;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
    .pc     (pc),
    .imm    (imm),
    .zero   (zero),
    .branch (branch),
    .jump   (jump),
    .pc_next(pc_next)
  );

  assign imem_addr = pc;

  // Outputs are registered alongside the state so each one reflects the
  // state being entered; handshakes seen on entry act on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!halt) begin
          state    <= FETCH;
          imem_req <= 1'b1;
          busy     <= 1'b1;
        end
        FETCH: if (imem_ack) begin
          state       <= ISSUE;
          instr       <= imem_rdata;
          imem_req    <= 1'b0;
          instr_valid <= 1'b1;
        end
        ISSUE: if (instr_ready) begin
          state       <= EXEC;
          instr_valid <= 1'b0;
        end
        EXEC: if (ex_done) begin
          pc       <= pc_next;
          state    <= halt ? IDLE : FETCH;
          imem_req <= !halt;
          busy     <= !halt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: table-driven self-checking bench for pc_ctrl with an address/instruction scoreboard.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        zero;
    logic        branch;
    logic        jump;
    logic [31:0] imm;
    logic [31:0] exp_next;
    int          ack_dly;
    int          done_dly;
  } vec_t;

  logic        clk = 0, rst_n = 0, halt = 0, imem_ack = 0, instr_ready = 0;
  logic        ex_done = 0, zero = 0, branch = 0, jump = 0;
  logic [31:0] imem_rdata = 0, imm = 0;
  logic        imem_req, instr_valid, busy;
  logic [31:0] imem_addr, instr, pc;
  int          n_cmp = 0, n_err = 0, cyc = 0, last_fetch = 0;
  logic [31:0] aq[$];
  logic [31:0] iq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .ex_done    (ex_done),
    .zero       (zero),
    .branch     (branch),
    .jump       (jump),
    .imm        (imm),
    .pc         (pc),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for a fetch request and compares its address with the scoreboard head.
  task automatic wait_fetch(input int period);
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      n_cmp++;
      n_err++;
      $display("FAIL fetch_timeout: imem_req got 0 expected 1");
    end else begin
      check("fetch_addr", imem_addr, aq.size() > 0 ? aq.pop_front() : 32'hx);
      if (period > 0) check("fetch_period", 32'(cyc - last_fetch), 32'(period));
      last_fetch = cyc;
    end
  endtask

  task automatic do_instr(input vec_t v, input logic hlt, input int period);
    logic [31:0] a0;
    wait_fetch(period);
    a0 = imem_addr;
    for (int i = 0; i < v.ack_dly; i++) begin
      ex_done = 1; jump = 1; imm = 32'h55; halt = 1; instr_ready = 1;
      @(negedge clk);
      check("stall_req", 32'(imem_req), 1);
      check("stall_addr", imem_addr, a0);
    end
    ex_done = 0; jump = 0; imm = 0; halt = 0; instr_ready = 0;
    imem_ack = 1; imem_rdata = v.rdata; iq.push_back(v.rdata);
    @(negedge clk);
    imem_ack = 0; imem_rdata = 32'hDEAD_BEEF;
    check("issue_valid", 32'(instr_valid), 1);
    check("issue_instr", instr, iq.size() > 0 ? iq.pop_front() : 32'hx);
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
    check("exec_valid", 32'(instr_valid), 0);
    for (int i = 0; i < v.done_dly; i++) begin
      imem_ack = 1; instr_ready = 1;
      @(negedge clk);
      imem_ack = 0; instr_ready = 0;
      check("exec_instr_hold", instr, v.rdata);
      check("exec_pc_hold", pc, a0);
    end
    zero = v.zero; branch = v.branch; jump = v.jump; imm = v.imm;
    ex_done = 1; halt = hlt;
    aq.push_back(v.exp_next);
    @(negedge clk);
    ex_done = 0; zero = 0; branch = 0; jump = 0; imm = 0;
  endtask

  initial begin
    vec_t tbl[11];
    vec_t v;
    tbl[0]  = '{32'h0010_0093, 0, 0, 0, 32'h0000_0000, 32'h0000_0001, 0, 0};
    tbl[1]  = '{32'h0020_0113, 0, 0, 0, 32'h0000_0000, 32'h0000_0002, 0, 0};
    tbl[2]  = '{32'h0060_006F, 0, 0, 1, 32'h0000_0006, 32'h0000_0008, 0, 0};
    tbl[3]  = '{32'hFE00_0EE3, 1, 1, 0, 32'hFFFF_FFFC, 32'h0000_0004, 0, 2};
    tbl[4]  = '{32'h0040_006F, 0, 0, 1, 32'h0000_0004, 32'h0000_0008, 0, 0};
    tbl[5]  = '{32'hFE10_0EE3, 0, 1, 0, 32'hFFFF_FFFC, 32'h0000_0009, 5, 0};
    tbl[6]  = '{32'h0000_0033, 1, 0, 0, 32'h0000_0100, 32'h0000_000A, 0, 0};
    tbl[7]  = '{32'hFF5F_F06F, 0, 0, 1, 32'hFFFF_FFF4, 32'hFFFF_FFFE, 0, 1};
    tbl[8]  = '{32'h0030_006F, 0, 0, 1, 32'h0000_0003, 32'h0000_0001, 0, 0};
    tbl[9]  = '{32'h0020_0063, 1, 1, 1, 32'h0000_0002, 32'h0000_0003, 0, 0};
    tbl[10] = '{32'h0070_0093, 0, 0, 0, 32'h0000_0007, 32'h0000_0004, 0, 0};

    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    rst_n = 1;
    aq.push_back(32'h0);
    @(negedge clk);
    check("rel_req", 32'(imem_req), 1);
    check("rel_busy", 32'(busy), 1);

    for (int i = 0; i < 11; i++)
      do_instr(tbl[i], 1'b0,
               (i > 0 && tbl[i-1].ack_dly == 0 && tbl[i-1].done_dly == 0) ? 3 : 0);

    // Halt together with ex_done at pc=4: lands in IDLE with pc=5.
    v = '{32'h0000_0013, 0, 0, 0, 32'h0000_0000, 32'h0000_0005, 0, 0};
    do_instr(v, 1'b1, 3);
    check("halt_busy", 32'(busy), 0);
    check("halt_req", 32'(imem_req), 0);
    check("halt_pc", pc, 32'h5);
    repeat (3) @(negedge clk);
    check("halt_idle_req", 32'(imem_req), 0);
    check("halt_idle_busy", 32'(busy), 0);
    halt = 0;
    v = '{32'h0000_0013, 0, 0, 0, 32'h0000_0000, 32'h0000_0006, 0, 0};
    do_instr(v, 1'b0, 0);

    // Reset while in ISSUE, followed by a stray ack that must not be captured.
    wait_fetch(3);
    imem_ack = 1; imem_rdata = 32'hABCD_0001;
    @(negedge clk);
    imem_ack = 0;
    check("mid_issue_valid", 32'(instr_valid), 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; imem_ack = 1; imem_rdata = 32'h1234_5678;
    check("mid_rst_valid", 32'(instr_valid), 0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_instr", instr, 32'h0000_0013);
    @(negedge clk);
    imem_ack = 0;
    check("post_rst_instr", instr, 32'h0000_0013);
    check("post_rst_valid", 32'(instr_valid), 0);
    aq.push_back(32'h0);
    v = '{32'h0010_0093, 0, 0, 0, 32'h0000_0000, 32'h0000_0001, 0, 0};
    do_instr(v, 1'b0, 0);
    wait_fetch(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
